aes_inv_cipher_iter: RTL and testbench

//   Iterative AES inverse cipher (decryption) datapath, one round per clock.

---
 rtl/aes_inv_cipher_iter_if.sv | 23 ++
 rtl/aes_inv_cipher_iter.sv | 163 ++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake and key-store bus of the iterative AES inverse cipher.
// The master side is the environment (ciphertext source, round-key store and
// plaintext sink). The slave side is the cipher block itself.
interface aes_inv_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock.
// Byte k of a 128-bit word sits at [127-8k -: 8] and maps to row k%4,
// column k/4 (column-major). Round keys are fetched combinationally from an
// external store addressed by rk_idx. rk_idx is simply the round counter: the
// counter rests at NR outside a block and reaches 0 exactly in the final round.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input logic                  clk,
  input logic                  rst,
  aes_inv_cipher_iter_if.slave bus
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} fsm_t;

  fsm_t         fsm_q;
  logic [127:0] state_q;
  logic [127:0] out_data_q;
  logic [3:0]   cnt_q;
  logic         in_ready_q;
  logic         out_valid_q;

  logic [127:0] isb_d;    // InvSubBytes(InvShiftRows(state))
  logic [127:0] ark_d;    // ... ^ round key (also the final-round result)
  logic [127:0] round_d;  // InvMixColumns of the above (full-round result)

  // GF(2^8) multiply by x, modulo 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply; only used inside the S-box inversion.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xt(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 by an addition chain; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    a252 = gf_mul(a240, a12);
    return gf_mul(a252, a2);
  endfunction

  // Inverse S-box: undo the affine map (rotl1 ^ rotl3 ^ rotl6 ^ 0x05), then invert.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // One column of InvMixColumns: circulant {0e,0b,0d,09} built from xtime chains.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0]  a  [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return r;
  endfunction

  genvar gi;

  // InvShiftRows is pure wiring: output byte (row, col) takes input (row, col-row mod 4).
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
      assign isb_d[127-8*gi -: 8] = inv_sbox(state_q[127-8*SRC -: 8]);
    end
  endgenerate

  assign ark_d = isb_d ^ bus.rk_data;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign round_d[127-32*gi -: 32] = inv_mix_col(ark_d[127-32*gi -: 32]);
    end
  endgenerate

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.rk_idx    = cnt_q;

  // Control FSM and datapath registers; all handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      out_data_q  <= '0;
      cnt_q       <= NR_IDX;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_q    <= bus.in_data ^ bus.rk_data;
            cnt_q      <= NR_IDX - 4'd1;
            in_ready_q <= 1'b0;
            fsm_q      <= S_ROUND;
          end
        end
        S_ROUND: begin
          state_q <= round_d;
          cnt_q   <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) fsm_q <= S_FINAL;
        end
        S_FINAL: begin
          out_data_q  <= ark_d;
          out_valid_q <= 1'b1;
          cnt_q       <= NR_IDX;
          fsm_q       <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= S_IDLE;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for the iterative AES inverse cipher. A forward AES model (S-box
// generated by the classic 3/(1/3) walk, byte-array rounds) produces
// ciphertexts; the expected output of every block is its original plaintext.
// Two instances: NR=10 (AES-128) and NR=14 (AES-256).
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rst_a, rst_b;

  aes_inv_cipher_iter_if bus_a ();
  aes_inv_cipher_iter_if bus_b ();

  aes_inv_cipher_iter #(.NR(10)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  aes_inv_cipher_iter #(.NR(14)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  // Round-key stores, read combinationally.
  logic [127:0] ks_a [0:15];
  logic [127:0] ks_b [0:15];
  assign bus_a.rk_data = ks_a[bus_a.rk_idx];
  assign bus_b.rk_data = ks_b[bus_b.rk_idx];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox [256];
  logic [127:0] mrk  [0:15];

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ m_xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Key expansion into mrk[0..nk+6]; key is top-aligned in 256 bits.
  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = m_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      mrk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ mrk[0][127-8*k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox[s[k]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++)
          s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++)
          for (int i = 0; i < 4; i++)
            t[4*c+i] = m_xt(s[4*c+i]) ^ m_xt(s[4*c+(i+1)%4]) ^ s[4*c+(i+1)%4]
                     ^ s[4*c+(i+2)%4] ^ s[4*c+(i+3)%4];
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ mrk[r][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // ---------------- scoreboard and compare process ----------------
  logic [127:0] exp_a[$], exp_b[$];
  int           out_t_a[$];
  bit           hold_a = 1'b0, hold_b = 1'b0;
  logic [127:0] held_a, held_b;

  always @(negedge clk) begin
    if (!rst_a) begin
      check("excl_a", 128'(bus_a.in_ready & bus_a.out_valid), 128'h0);
      if (hold_a) begin
        check("hold_valid_a", 128'(bus_a.out_valid), 128'h1);
        check("hold_data_a", bus_a.out_data, held_a);
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (exp_a.size() == 0) check("unexpected_out_a", bus_a.out_data, 128'hx);
        else check("data_a", bus_a.out_data, exp_a.pop_front());
        out_t_a.push_back(cyc);
      end
      hold_a = bus_a.out_valid && !bus_a.out_ready;
      held_a = bus_a.out_data;
    end else hold_a = 1'b0;
    if (!rst_b) begin
      check("excl_b", 128'(bus_b.in_ready & bus_b.out_valid), 128'h0);
      if (hold_b) begin
        check("hold_valid_b", 128'(bus_b.out_valid), 128'h1);
        check("hold_data_b", bus_b.out_data, held_b);
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (exp_b.size() == 0) check("unexpected_out_b", bus_b.out_data, 128'hx);
        else check("data_b", bus_b.out_data, exp_b.pop_front());
      end
      hold_b = bus_b.out_valid && !bus_b.out_ready;
      held_b = bus_b.out_data;
    end else hold_b = 1'b0;
  end

  // ---------------- drivers (called at posedge+#1) ----------------
  task automatic drive_in(input bit b, input logic v, input logic [127:0] d);
    if (b) begin bus_b.in_valid = v; bus_b.in_data = d; end
    else   begin bus_a.in_valid = v; bus_a.in_data = d; end
  endtask

  function automatic logic rd_in_ready(input bit b);
    return b ? bus_b.in_ready : bus_a.in_ready;
  endfunction

  task automatic send(input bit b, input logic [127:0] ct, input logic [127:0] pt, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    drive_in(b, 1'b1, ct);
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (rd_in_ready(b)) begin
        if (b) exp_b.push_back(pt); else exp_a.push_back(pt);
        acc = cyc;
        ok  = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("accept", 128'(ok), 128'h1);
  endtask

  task automatic drain(input bit b);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge clk); #1;
      if ((b ? exp_b.size() : exp_a.size()) == 0 && rd_in_ready(b)) done = 1'b1;
    end
    check("drain", 128'(done), 128'h1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int acc [3];
    logic [127:0] pt, ct;
    logic [255:0] key;

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;

    // Model pins against FIPS-197 literals.
    build_sbox();
    check("pin_sbox53", 128'(sbox[8'h53]), 128'hed);
    expand(KEY_C3, 8);
    ks_b = mrk;
    check("pin_enc_c3", model_encrypt(PT_C, 14), CT_C3);
    expand(KEY_C1, 4);
    ks_a = mrk;
    check("pin_rk10_c1", ks_a[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("pin_enc_c1", model_encrypt(PT_C, 10), CT_C1);

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(bus_a.in_ready), 128'h1);
    check("rst_out_valid", 128'(bus_a.out_valid), 128'h0);
    check("rst_out_data", bus_a.out_data, 128'h0);
    check("rst_rk_idx_a", 128'(bus_a.rk_idx), 128'd10);
    check("rst_rk_idx_b", 128'(bus_b.rk_idx), 128'd14);
    @(posedge clk); #1;

    // C.1 block: rk_idx trace and latency, then 20 cycles of backpressure.
    drive_in(1'b0, 1'b1, CT_C1);
    @(negedge clk);
    check("acc_rk_idx", 128'(bus_a.rk_idx), 128'd10);
    check("acc_rk_data", bus_a.rk_data, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("acc_in_ready", 128'(bus_a.in_ready), 128'h1);
    exp_a.push_back(PT_C);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b0, 128'h0);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j <= 9) check($sformatf("trace_rk_idx_%0d", j), 128'(bus_a.rk_idx), 128'(10 - j));
      if (j == 10) begin
        check("final_rk_idx", 128'(bus_a.rk_idx), 128'd0);
        check("latency_not_early", 128'(bus_a.out_valid), 128'h0);
      end
      if (j == 11) begin
        check("latency_valid", 128'(bus_a.out_valid), 128'h1);
        check("c1_plaintext", bus_a.out_data, PT_C);
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      drive_in(1'b0, (k % 3) == 0, {$urandom, $urandom, $urandom, $urandom});
      @(negedge clk);
      check("bp_in_ready", 128'(bus_a.in_ready), 128'h0);
    end
    @(posedge clk); #1;
    drive_in(1'b0, 1'b0, 128'h0);
    bus_a.out_ready = 1'b1;
    drain(1'b0);

    // Back-to-back: in_valid and out_ready held high, NR+2 cycles apart.
    out_t_a.delete();
    for (int i = 0; i < 3; i++) begin
      pt = PT_C ^ {16{8'(8'h11 * i)}};
      send(1'b0, model_encrypt(pt, 10), pt, acc[i]);
    end
    drive_in(1'b0, 1'b0, 128'h0);
    drain(1'b0);
    check("b2b_acc_gap1", 128'(acc[1] - acc[0]), 128'd12);
    check("b2b_acc_gap2", 128'(acc[2] - acc[1]), 128'd12);
    check("b2b_out_count", 128'(out_t_a.size()), 128'd3);
    if (out_t_a.size() == 3) begin
      check("b2b_out_gap1", 128'(out_t_a[1] - out_t_a[0]), 128'd12);
      check("b2b_out_gap2", 128'(out_t_a[2] - out_t_a[1]), 128'd12);
    end

    // Reset in the middle of ROUND (cnt=5), then a clean C.1 block.
    send(1'b0, CT_C1, PT_C, acc[0]);
    drive_in(1'b0, 1'b0, 128'h0);
    for (int n = 0; n < 20 && bus_a.rk_idx != 4'd5; n++) begin
      @(posedge clk); #1;
    end
    check("mid_rk_idx", 128'(bus_a.rk_idx), 128'd5);
    rst_a = 1'b1;
    exp_a.delete();
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 128'(bus_a.in_ready), 128'h1);
    check("mid_rst_out_valid", 128'(bus_a.out_valid), 128'h0);
    check("mid_rst_rk_idx", 128'(bus_a.rk_idx), 128'd10);
    @(posedge clk); #1;
    send(1'b0, CT_C1, PT_C, acc[0]);
    drive_in(1'b0, 1'b0, 128'h0);
    drain(1'b0);

    // Round-trip: random AES-128 keys and plaintexts.
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      expand(key, 4);
      ks_a = mrk;
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = model_encrypt(pt, 10);
      send(1'b0, ct, pt, acc[0]);
      drive_in(1'b0, 1'b0, 128'h0);
      drain(1'b0);
    end

    // NR=14: FIPS-197 C.3, then random AES-256 round-trips.
    send(1'b1, CT_C3, PT_C, acc[0]);
    drive_in(1'b1, 1'b0, 128'h0);
    drain(1'b1);
    for (int i = 0; i < 50; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand(key, 8);
      ks_b = mrk;
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = model_encrypt(pt, 14);
      send(1'b1, ct, pt, acc[0]);
      drive_in(1'b1, 1'b0, 128'h0);
      drain(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
